// File: rtl/audio_dec_pkg.sv
// Shared types and default parameters for the audio decimation stage.
package audio_dec_pkg;

   typedef enum logic {DEC_PICK, DEC_AVG} dec_mode_t;
   typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

   localparam int DEF_N        = 16;
   localparam int DEF_W        = 32;
   localparam int DEF_FRAC     = 8;
   localparam int DEF_MAX_LOG2 = 6;
   localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry valid/ready output buffer; a load arriving while the held word
// is stalled is discarded and reported on the drop strobe.
module stream_hold_reg
   import audio_dec_pkg::*;
#(
   parameter int W = DEF_W
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         drop
);

   buf_state_t   state_reg, state_next;
   logic [W-1:0] data_reg, data_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= BUF_EMPTY;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      drop       = 1'b0;
      case (state_reg)
         BUF_EMPTY: begin
            if (load) begin
               state_next = BUF_FULL;
               data_next  = load_data;
            end
         end
         BUF_FULL: begin
            // Simultaneous transfer and load keeps the buffer full with no bubble
            if (load) begin
               if (ready) data_next = load_data;
               else       drop      = 1'b1;
            end else if (ready) begin
               state_next = BUF_EMPTY;
            end
         end
         default: state_next = BUF_EMPTY;
      endcase
   end

   assign valid = (state_reg == BUF_FULL);
   assign data  = data_reg;

endmodule

// File: rtl/audio_decimator.sv
// Decimates codec samples by 2^D (pick or boxcar average) into FFT-format
// words, counting results lost to downstream back-pressure.
module audio_decimator
   import audio_dec_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int W        = DEF_W,
   parameter int FRAC     = DEF_FRAC,
   parameter int MAX_LOG2 = DEF_MAX_LOG2,
   parameter int CNT_W    = DEF_CNT_W
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            x_valid,
   output logic                            x_ready,
   input  logic [N-1:0]                    x_data,
   output logic                            y_valid,
   input  logic                            y_ready,
   output logic [W-1:0]                    y_data,
   input  logic [$clog2(MAX_LOG2+1)-1:0]   dec_log2,
   input  logic                            mode,
   output logic [CNT_W-1:0]                drop_count
);

   localparam int DW = $clog2(MAX_LOG2 + 1);
   localparam int IW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
   localparam int AW = N + MAX_LOG2;

   logic [DW-1:0]          d_req, d_q, d_cur;
   dec_mode_t              mode_q, mode_cur;
   logic [IW-1:0]          idx_reg, idx_next, last_idx;
   logic signed [AW-1:0]   acc_reg, acc_next, sample_ext, sum, avg;
   logic                   group_start, group_last, result_valid, drop;
   logic [N-1:0]           result;
   logic signed [W-1:0]    result_ext;
   logic [W-1:0]           result_word;
   logic [CNT_W-1:0]       drop_count_reg;

   assign x_ready = 1'b1;

   always_comb begin
      d_req       = (dec_log2 > DW'(MAX_LOG2)) ? DW'(MAX_LOG2) : dec_log2;
      group_start = (idx_reg == '0);
      // The first sample of a group already uses the freshly requested settings
      d_cur       = group_start ? d_req : d_q;
      mode_cur    = group_start ? dec_mode_t'(mode) : mode_q;
      last_idx    = IW'((32'd1 << d_cur) - 32'd1);
      group_last  = (idx_reg == last_idx);
      result_valid = x_valid && group_last;

      sample_ext  = AW'($signed(x_data));
      sum         = (group_start ? '0 : acc_reg) + sample_ext;
      avg         = sum >>> d_cur;
      result      = (mode_cur == DEC_AVG) ? avg[N-1:0] : x_data;
      result_ext  = W'($signed(result));
      result_word = result_ext << FRAC;

      idx_next = idx_reg;
      acc_next = acc_reg;
      if (x_valid) begin
         idx_next = group_last ? '0 : idx_reg + IW'(1);
         acc_next = sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_reg        <= '0;
         acc_reg        <= '0;
         d_q            <= d_req;
         mode_q         <= dec_mode_t'(mode);
         drop_count_reg <= '0;
      end else begin
         idx_reg <= idx_next;
         acc_reg <= acc_next;
         if (x_valid && group_start) begin
            d_q    <= d_req;
            mode_q <= dec_mode_t'(mode);
         end
         if (drop && (drop_count_reg != '1))
            drop_count_reg <= drop_count_reg + CNT_W'(1);
      end
   end

   assign drop_count = drop_count_reg;

   stream_hold_reg #(.W(W)) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load      (result_valid),
      .load_data (result_word),
      .valid     (y_valid),
      .ready     (y_ready),
      .data      (y_data),
      .drop      (drop)
   );

endmodule

// File: tb/tb_audio_decimator.sv
// Directed bench for audio_decimator: pick/average results, back-pressure
// drops, mid-group control changes, reset and exponent clamping.
module tb_audio_decimator;
   import audio_dec_pkg::*;

   logic        clk = 1'b0;
   logic        reset, x_valid, mode, y_ready;
   logic [15:0] x_data;
   logic [2:0]  dec_log2;
   logic        x_ready, y_valid;
   logic [31:0] y_data;
   logic [15:0] drop_count;
   logic        s_x_ready, s_y_valid;
   logic [31:0] s_y_data;
   logic [1:0]  s_drop_count;

   int total = 0;
   int bad   = 0;
   int nout;

   always #5 clk = ~clk;

   audio_decimator dut (
      .clk(clk), .reset(reset),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .dec_log2(dec_log2), .mode(mode), .drop_count(drop_count)
   );

   audio_decimator #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .x_valid(x_valid), .x_ready(s_x_ready), .x_data(x_data),
      .y_valid(s_y_valid), .y_ready(y_ready), .y_data(s_y_data),
      .dec_log2(dec_log2), .mode(mode), .drop_count(s_drop_count)
   );

   always @(negedge clk)
      if (y_valid && y_ready) $display("xfer data=%h drops=%0d", y_data, drop_count);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] s);
      x_valid = 1'b1;
      x_data  = s;
      tick();
      x_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      x_valid = 1'b0;
      tick();
      tick();
      reset   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; x_valid = 1'b0; x_data = '0; mode = 1'b0;
      y_ready = 1'b1; dec_log2 = 3'd6;

      // Pick every 64th sample
      do_reset();
      check("rst_valid", y_valid, 0);
      check("rst_data", y_data, 0);
      check("rst_drops", drop_count, 0);
      nout = 0;
      for (int i = 0; i < 128; i++) begin
         push(16'(i));
         if (y_valid) nout++;
         if (i == 63) begin
            check("pick63_v", y_valid, 1);
            check("pick63_d", y_data, 32'h0000_3F00);
         end
         if (i == 127) begin
            check("pick127_v", y_valid, 1);
            check("pick127_d", y_data, 32'h0000_7F00);
         end
      end
      check("pick_count", nout, 2);

      // Average of four, positive and negative
      dec_log2 = 3'd2; mode = 1'b1;
      do_reset();
      push(16'd4); push(16'd5); push(16'd6);
      check("avg_early", y_valid, 0);
      push(16'd7);
      check("avg_pos", y_data, 32'h0000_0500);
      push(16'hFFFF); push(16'hFFFE); push(16'hFFFE); push(16'hFFFE);
      check("avg_neg_v", y_valid, 1);
      check("avg_neg", y_data, 32'hFFFF_FE00);

      // Back-pressure at D=0: hold first word, count drops
      dec_log2 = 3'd0; mode = 1'b0; y_ready = 1'b0;
      do_reset();
      for (int s = 1; s <= 5; s++) push(16'(s));
      check("bp_hold", y_data, 32'h0000_0100);
      check("bp_valid", y_valid, 1);
      check("bp_drops", drop_count, 4);
      check("sat_drops", s_drop_count, 3);
      y_ready = 1'b1;
      push(16'd6);
      check("bp_reload_v", y_valid, 1);
      check("bp_reload_d", y_data, 32'h0000_0600);
      check("bp_drops2", drop_count, 4);
      tick();
      check("bp_empty", y_valid, 0);

      // Reset in the middle of a D=3 group
      dec_log2 = 3'd3; y_ready = 1'b0;
      push(16'd1); push(16'd2); push(16'd3);
      do_reset();
      check("mid_rst_v", y_valid, 0);
      check("mid_rst_drops", drop_count, 0);
      check("mid_rst_sat", s_drop_count, 0);
      y_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(16'(20 + i));
         if (i < 7) check("mid_rst_nv", y_valid, 0);
      end
      check("mid_rst_out_v", y_valid, 1);
      check("mid_rst_out_d", y_data, 32'h0000_1B00);
      tick();

      // Exponent change mid-group takes effect at the next group
      dec_log2 = 3'd2;
      push(16'd10); push(16'd11);
      dec_log2 = 3'd1;
      push(16'd12);
      check("sw_nv12", y_valid, 0);
      push(16'd13);
      check("sw_v13", y_valid, 1);
      check("sw_d13", y_data, 32'h0000_0D00);
      push(16'd14);
      check("sw_nv14", y_valid, 0);
      push(16'd15);
      check("sw_v15", y_valid, 1);
      check("sw_d15", y_data, 32'h0000_0F00);
      tick();

      // dec_log2=7 clamps to 6: average of 0..63 = 2016>>>6 = 31
      dec_log2 = 3'd7; mode = 1'b1;
      nout = 0;
      for (int i = 0; i < 64; i++) begin
         push(16'(i));
         if (y_valid) nout++;
      end
      check("clamp_v", y_valid, 1);
      check("clamp_d", y_data, 32'h0000_1F00);
      check("clamp_count", nout, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_decimator.md
# audio_decimator

Parametrised decimation stage between `audio_codec_data` and `fft_stream`, replacing the fixed keep-every-64th-sample logic in the microphone top level. Supports a runtime decimation factor 2^D (D = 0..MAX_LOG2) and two modes: pick (keep the last sample of each group) or average (boxcar accumulate-and-dump). Output is the FFT word format with a one-entry output buffer. A saturating counter records results lost to FFT back-pressure.

## Interface
Parameters:
- `N`, 16, input sample width (two's complement)
- `W`, 32, output word width; must satisfy W ≥ N + FRAC
- `FRAC`, 8, zero LSBs appended below the sample in the output word
- `MAX_LOG2`, 6, largest supported decimation exponent
- `CNT_W`, 16, drop counter width

Ports:
- `clk`  in  1  sample-domain clock (adc_clk in the top level)
- `reset`  in  1  synchronous, active-high
- `x`  dstream slave  N  codec samples; `x.ready` tied to 1
- `y`  dstream master  W  decimated words to FFT
- `dec_log2`  in  $clog2(MAX_LOG2+1)  requested D; values above MAX_LOG2 clamp to MAX_LOG2
- `mode`  in  1  0 = DEC_PICK, 1 = DEC_AVG
- `drop_count`  out  CNT_W  saturating count of dropped results

## Operation
- One clock and one reset. Reset is synchronous and active-high.
- `x.ready` is constant 1. Every cycle with `x.valid` high accepts a sample (the codec has no back-pressure).
- Group counter `idx` counts accepted samples from 0 to 2^D−1, then wraps to 0.
- Shadow registers `d_q`/`mode_q` load from `dec_log2`/`mode` on the acceptance where `idx==0`, and also during reset. Changes in mid-group take effect at the next group start.
- D=0: every accepted sample completes a group.
- DEC_PICK: the result is the sample accepted at `idx==2^D−1`.
- DEC_AVG: the accumulator `acc` is N+MAX_LOG2 bits and holds the sign-extended sum.
  - At `idx==0`, `acc` loads the sample.
  - On other acceptances, `acc` adds the sample.
  - At the last sample, the result is (acc + sample) >>> D, arithmetic shift, truncated toward −∞, then cut to N bits. No overflow is possible.
- Output formatting: `y.data` = {(W−N−FRAC) copies of result sign bit, result[N−1:0], FRAC zeros}.
- Output buffer states are EMPTY and FULL. On a group completion (result event):
  - EMPTY → FULL, loading the result.
  - FULL with `y.ready`=1 → stay FULL, load the new result (the old word is transferred this cycle).
  - FULL with `y.ready`=0 → stay FULL, keep the held word unchanged, discard the new result, increment `drop_count`. `drop_count` saturates at 2^CNT_W−1.
- With no result event, FULL with `y.ready`=1 → EMPTY.
- `y.valid` is asserted in FULL. `y.data` is stable while `y.valid && !y.ready`.
- Reset values: `y.valid`=0, `y.data`=0, `drop_count`=0, `idx`=0, `acc`=0. A reset mid-group discards the partial group.

## Timing
- Latency: the result appears on `y` the cycle after the last sample of the group is accepted.
- Peak throughput is one word per cycle at D=0 with `y.ready` held high.
- `y.valid` never depends combinationally on `y.ready`. `y.ready` may depend on `y.valid`.
- No combinational path runs from `x` to `y`.
- Result event and `y.ready` in the same cycle: handled as above, with no drop and no bubble.

## Structure
- Package `audio_dec_pkg`:
  - `typedef enum logic {DEC_PICK, DEC_AVG} dec_mode_t`
  - `typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t`
  - default constants for N, W, FRAC, MAX_LOG2
- Sub-module `stream_hold_reg`: a one-entry valid/ready output buffer with W-bit data, a `load` input and a `drop` strobe output. The decimator drives `drop_count` from the `drop` strobe.
- Group counter, shadow registers, accumulator and formatting stay in `audio_decimator`.

## Test plan
- D=6, PICK, `y.ready`=1, x.valid every cycle, samples 0..127 → exactly 2 outputs: data 0x00003F00 and 0x00007F00, each one cycle after samples 63 and 127.
- D=2, AVG, samples 4, 5, 6, 7 then −1, −2, −2, −2 → outputs 0x00000500 (sum 22, 22>>>2 = 5) and 0xFFFFFE00 (sum −7, −7>>>2 = −2).
- D=0, `y.ready`=0 for 5 cycles, x.valid every cycle with samples 1..5 → `y.data` held at 0x00000100, `drop_count`=4. `y.ready`=1 on the next sample 6 → word 1 transfers and 6 loads in the same cycle with no bubble.
- `dec_log2` switched from 2 to 1 after the 2nd sample of a group → the current group still completes after 4 samples; the next group completes after 2.
- `reset` asserted after 3 of 8 samples in a D=3 group → `y.valid`=0, `drop_count`=0; next output only after 8 fresh samples. `dec_log2`=7 with MAX_LOG2=6 behaves as D=6.
- `CNT_W`=2 and 5 drops forced → `drop_count` saturates at 3.
